// File: rtl/adder_nibble_sequencer_pkg.sv
// Shared definitions for the nibble-serial adder/subtractor.
//   state_t  : sequencer FSM encoding (IDLE, RUN, DONE)
//   NIBBLE_W : width of the shared adder slice
package adder_nibble_sequencer_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/adder_nibble_sequencer_if.sv
// Request/response bundle of the nibble-serial adder/subtractor.
//   request : in_valid, in_ready, a, b, cin, sub
//   response: out_valid, out_ready, sum, cout, ovf
//   status  : busy
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both 1. The producer holds its payload stable while valid=1 and ready=0;
// ready never depends combinationally on valid.
interface adder_nibble_sequencer_if #(
  parameter int W = 16
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic         busy;

  // Requesting datapath / consumer side
  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, busy
  );

  // Sequencer side
  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf, busy
  );
endinterface

// File: rtl/adder_nibble_sequencer_ripple_adder_4bit.sv
// Combinational 4-bit ripple-carry adder slice shared by all nibbles.
//   x, y : nibble operands
//   ci   : carry in
//   s    : nibble sum
//   co   : carry out of bit 3
module ripple_adder_4bit (
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);
  logic [4:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign s[i]   = x[i] ^ y[i] ^ c[i];
    assign c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
  end

  assign co = c[4];
endmodule

// File: rtl/adder_nibble_sequencer.sv
// Nibble-serial adder/subtractor: adds 4*NIBBLES-bit operands through one
// shared 4-bit ripple slice, LSB nibble first, one nibble per clock.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : request/response handshakes (slave modport)
//   dbg_state  : current FSM state for observation
module adder_nibble_sequencer
  import adder_nibble_sequencer_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  adder_nibble_sequencer_if.slave       bus,
  output state_t                        dbg_state
);
  localparam int W  = NIBBLE_W * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

  if (NIBBLES < 1 || NIBBLES > 16) begin : g_bad_nibbles
    $error("adder_nibble_sequencer: NIBBLES must be in 1..16");
  end

  state_t        state, next_state;
  logic [W-1:0]  a_r, b_r, sum_r;
  logic [IW-1:0] index;
  logic          carry, cout_r, ovf_r;
  logic          accept, last;
  logic [3:0]    slice_x, slice_y, slice_s;
  logic          slice_co;

  assign accept = bus.in_valid && (state == IDLE);
  assign last   = (index == LAST_IDX);

  assign slice_x = a_r[index*NIBBLE_W +: NIBBLE_W];
  assign slice_y = b_r[index*NIBBLE_W +: NIBBLE_W];

  ripple_adder_4bit u_slice (
    .x  (slice_x),
    .y  (slice_y),
    .ci (carry),
    .s  (slice_s),
    .co (slice_co)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = RUN;
      RUN:     if (last) next_state = DONE;
      DONE:    if (bus.out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Subtraction is A + ~B + 1: B is inverted on capture and the initial
  // carry forced to 1, so RUN is identical for both operations.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r    <= '0;
      b_r    <= '0;
      sum_r  <= '0;
      index  <= '0;
      carry  <= 1'b0;
      cout_r <= 1'b0;
      ovf_r  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_r   <= bus.a;
            b_r   <= bus.sub ? ~bus.b : bus.b;
            carry <= bus.sub ? 1'b1 : bus.cin;
            index <= '0;
          end
        end
        RUN: begin
          sum_r[index*NIBBLE_W +: NIBBLE_W] <= slice_s;
          carry <= slice_co;
          if (last) begin
            index  <= '0;
            cout_r <= slice_co;
            // Signed overflow: operands (post-inversion) agree in sign but
            // the top result bit differs.
            ovf_r  <= (a_r[W-1] == b_r[W-1]) && (slice_s[3] != a_r[W-1]);
          end else begin
            index <= index + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state != IDLE);
  assign bus.sum       = sum_r;
  assign bus.cout      = cout_r;
  assign bus.ovf       = ovf_r;
  assign dbg_state     = state;
endmodule

// File: tb/tb_adder_nibble_sequencer.sv
// Bench for adder_nibble_sequencer: a NIBBLES=4 instance for the main
// directed vectors, backpressure and async reset, plus a NIBBLES=1 instance.
module tb_adder_nibble_sequencer;
  import adder_nibble_sequencer_pkg::*;

  localparam int N  = 4;
  localparam int W  = 16;
  localparam int N1 = 1;
  localparam int W1 = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  adder_nibble_sequencer_if #(.W(W))  bus ();
  adder_nibble_sequencer_if #(.W(W1)) bus1 ();
  state_t st0, st1;

  adder_nibble_sequencer #(.NIBBLES(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (st0)
  );

  adder_nibble_sequencer #(.NIBBLES(N1)) dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus1),
    .dbg_state (st1)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;
  logic [W+1:0]  exp_q[$];
  logic [W1+1:0] exp1_q[$];
  int accept_cyc = 0;
  int accept1_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s", name);
  endtask

  // Monitor for the NIBBLES=4 instance
  logic ov0_prev = 1'b0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.out_valid && !ov0_prev)
        check("latency4", cyc - accept_cyc, N);
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) fail_now("unexpected_result4");
        else check("result4", {bus.sum, bus.cout, bus.ovf}, exp_q.pop_front());
      end
      ov0_prev = bus.out_valid;
    end else begin
      ov0_prev = 1'b0;
    end
  end

  // Monitor for the NIBBLES=1 instance
  logic ov1_prev = 1'b0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus1.out_valid && !ov1_prev)
        check("latency1", cyc - accept1_cyc, N1);
      if (bus1.out_valid && bus1.out_ready) begin
        if (exp1_q.size() == 0) fail_now("unexpected_result1");
        else check("result1", {bus1.sum, bus1.cout, bus1.ovf}, exp1_q.pop_front());
      end
      ov1_prev = bus1.out_valid;
    end else begin
      ov1_prev = 1'b0;
    end
  end

  // ---------------- drivers ----------------
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                       input logic sub, input logic [W-1:0] e_sum, input logic e_cout,
                       input logic e_ovf);
    int n;
    @(negedge clk);
    bus.a = a; bus.b = b; bus.cin = cin; bus.sub = sub; bus.in_valid = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      fail_now("accept_timeout4");
      bus.in_valid = 1'b0;
      return;
    end
    exp_q.push_back({e_sum, e_cout, e_ovf});
    @(posedge clk);
    #1;
    accept_cyc = cyc;
    bus.in_valid = 1'b0;
  endtask

  task automatic issue1(input logic [W1-1:0] a, input logic [W1-1:0] b, input logic cin,
                        input logic sub, input logic [W1-1:0] e_sum, input logic e_cout,
                        input logic e_ovf);
    int n;
    @(negedge clk);
    bus1.a = a; bus1.b = b; bus1.cin = cin; bus1.sub = sub; bus1.in_valid = 1'b1;
    n = 0;
    while (!bus1.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus1.in_ready) begin
      fail_now("accept_timeout1");
      bus1.in_valid = 1'b0;
      return;
    end
    exp1_q.push_back({e_sum, e_cout, e_ovf});
    @(posedge clk);
    #1;
    accept1_cyc = cyc;
    bus1.in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || exp1_q.size() != 0 || bus.busy || bus1.busy) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) fail_now(name);
  endtask

  // ---------------- stimulus ----------------
  logic [W+1:0] held;
  int n;

  initial begin
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.sub = 1'b0;
    bus.out_ready = 1'b1;
    bus1.in_valid = 1'b0; bus1.a = '0; bus1.b = '0; bus1.cin = 1'b0; bus1.sub = 1'b0;
    bus1.out_ready = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_sum", bus.sum, 0);
    check("rst_cout_ovf", {bus.cout, bus.ovf}, 0);
    check("rst_state", st0, IDLE);
    rst_n = 1'b1;

    // Basic add, carry ripple through all nibbles, signed overflow
    issue(16'h0003, 16'h0001, 1'b0, 1'b0, 16'h0004, 1'b0, 1'b0);
    drain("drain_t1");
    issue(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    drain("drain_t2a");
    issue(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    drain("drain_t2b");
    issue(16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0);
    drain("drain_cin");

    // Subtract (cin ignored)
    issue(16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    drain("drain_t3a");
    issue(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    drain("drain_t3b");

    // Backpressure: result held, stray request ignored
    bus.out_ready = 1'b0;
    issue(16'h0F0F, 16'h0101, 1'b0, 1'b0, 16'h1010, 1'b0, 1'b0);
    n = 0;
    while (!bus.out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.out_valid) fail_now("bp_valid_timeout");
    held = {16'h1010, 1'b0, 1'b0};
    for (int i = 0; i < 5; i++) begin
      check("bp_stable", {bus.sum, bus.cout, bus.ovf}, held);
      check("bp_in_ready", bus.in_ready, 0);
      check("bp_out_valid", bus.out_valid, 1);
      if (i == 1) begin
        bus.a = 16'h1111; bus.b = 16'h0000; bus.in_valid = 1'b1;
      end
      if (i == 3) bus.in_valid = 1'b0;
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    check("bp_back_idle", {bus.in_ready, bus.out_valid, bus.busy}, 3'b100);
    issue(16'hABCD, 16'h1111, 1'b0, 1'b0, 16'hBCDE, 1'b0, 1'b0);
    drain("drain_t4");

    // Asynchronous reset two cycles into RUN
    issue(16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2;
    check("pre_rst_busy", bus.busy, 1);
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", bus.out_valid, 0);
    check("arst_busy", bus.busy, 0);
    check("arst_sum", bus.sum, 0);
    check("arst_cout_ovf", {bus.cout, bus.ovf}, 0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    issue(16'h00F0, 16'h0010, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);
    drain("drain_t5");

    // NIBBLES=1 instance
    issue1(4'hF, 4'h1, 1'b1, 1'b0, 4'h1, 1'b1, 1'b0);
    drain("drain_t6a");
    issue1(4'h7, 4'h1, 1'b0, 1'b0, 4'h8, 1'b0, 1'b1);
    drain("drain_t6b");
    issue1(4'h3, 4'h5, 1'b0, 1'b1, 4'hE, 1'b0, 1'b0);
    drain("drain_t6c");

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "simulation time limit");
  end
endmodule
